// File: rtl/fp_rf_pkg.sv
// Shared types and default sizing for the multi-port FP register file.
// Optional same-cycle bypass is enabled by defining FP_RF_BYPASS_EN.
package fp_rf_pkg;

  localparam int FP_RF_DATA_W = 32;
  localparam int FP_RF_DEPTH  = 32;
  localparam int FP_RF_NUM_RD = 3;

  typedef enum logic [1:0] {
    CLR_IDLE  = 2'd0,
    CLR_SWEEP = 2'd1,
    CLR_DONE  = 2'd2
  } clr_state_e;

endpackage

// File: rtl/fp_rf_clr_seq.sv
// Clear sequencer: walks every register index once, one per cycle, then
// pulses done. Outputs are registered so the file sees a clean strobe.
//
// state     | meaning
// ----------+-----------------------------------------------------
// CLR_IDLE  | waiting for a clear request
// CLR_SWEEP | zeroing reg[ptr] and pend[ptr] each cycle, ptr++
// CLR_DONE  | one-cycle completion pulse, then back to idle
module fp_rf_clr_seq
  import fp_rf_pkg::*;
#(
  parameter  int DEPTH  = FP_RF_DEPTH,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_clr_req,
  output logic              o_clr_stb,
  output logic [ADDR_W-1:0] o_clr_idx,
  output logic              o_clr_busy,
  output logic              o_clr_done
);

  clr_state_e        r_state;
  logic [ADDR_W-1:0] r_ptr;
  logic              r_busy;
  logic              r_done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= CLR_IDLE;
      r_ptr   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        CLR_IDLE: begin
          r_done <= 1'b0;
          if (i_clr_req) begin
            r_state <= CLR_SWEEP;
            r_ptr   <= '0;
            r_busy  <= 1'b1;
          end
        end
        CLR_SWEEP: begin
          r_ptr <= r_ptr + 1'b1;
          if (r_ptr == ADDR_W'(DEPTH - 1)) begin
            r_state <= CLR_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        CLR_DONE: begin
          r_state <= CLR_IDLE;
          r_done  <= 1'b0;
        end
        default: begin
          r_state <= CLR_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  // Busy is only ever high in SWEEP, so it doubles as the clear strobe.
  assign o_clr_stb  = r_busy;
  assign o_clr_idx  = r_ptr;
  assign o_clr_busy = r_busy;
  assign o_clr_done = r_done;

endmodule

// File: rtl/fp_regfile_mp.sv
// Multi-port FP register file with dual writeback, pending scoreboard and
// sequenced clear. Define FP_RF_BYPASS_EN for same-cycle write-to-read bypass.
module fp_regfile_mp
  import fp_rf_pkg::*;
#(
  parameter  int DATA_W = FP_RF_DATA_W,
  parameter  int DEPTH  = FP_RF_DEPTH,
  parameter  int NUM_RD = FP_RF_NUM_RD,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_RD*ADDR_W-1:0] i_rd_addr,
  output logic [NUM_RD*DATA_W-1:0] o_rd_data,
  output logic [NUM_RD-1:0]        o_rd_pend,
  input  logic                     i_wr0_en,
  input  logic [ADDR_W-1:0]        i_wr0_addr,
  input  logic [DATA_W-1:0]        i_wr0_data,
  input  logic                     i_wr1_en,
  input  logic [ADDR_W-1:0]        i_wr1_addr,
  input  logic [DATA_W-1:0]        i_wr1_data,
  input  logic                     i_sb_set_en,
  input  logic [ADDR_W-1:0]        i_sb_set_addr,
  input  logic                     i_clr_req,
  output logic                     o_clr_busy,
  output logic                     o_clr_done
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DEPTH-1:0]  r_pend;
  logic              w_clr_stb;
  logic [ADDR_W-1:0] w_clr_idx;

  fp_rf_clr_seq #(.DEPTH(DEPTH)) u_clr_seq (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_clr_req  (i_clr_req),
    .o_clr_stb  (w_clr_stb),
    .o_clr_idx  (w_clr_idx),
    .o_clr_busy (o_clr_busy),
    .o_clr_done (o_clr_done)
  );

  // wr0 is the younger instruction, so it is applied last and wins a tie;
  // likewise a scoreboard set overrides a same-index wr1 clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_pend <= '0;
    end else if (w_clr_stb) begin
      r_mem[w_clr_idx]  <= '0;
      r_pend[w_clr_idx] <= 1'b0;
    end else begin
      if (i_wr1_en)    r_mem[i_wr1_addr]     <= i_wr1_data;
      if (i_wr0_en)    r_mem[i_wr0_addr]     <= i_wr0_data;
      if (i_wr1_en)    r_pend[i_wr1_addr]    <= 1'b0;
      if (i_sb_set_en) r_pend[i_sb_set_addr] <= 1'b1;
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_data;
    logic              w_pend;

    assign w_addr = i_rd_addr[k*ADDR_W +: ADDR_W];

    always_comb begin
      w_data = r_mem[w_addr];
      w_pend = r_pend[w_addr];
`ifdef FP_RF_BYPASS_EN
      if (!w_clr_stb) begin
        if (i_wr0_en && (i_wr0_addr == w_addr))      w_data = i_wr0_data;
        else if (i_wr1_en && (i_wr1_addr == w_addr)) w_data = i_wr1_data;
        if (i_sb_set_en && (i_sb_set_addr == w_addr)) w_pend = 1'b1;
        else if (i_wr1_en && (i_wr1_addr == w_addr))  w_pend = 1'b0;
      end
`endif
    end

    assign o_rd_data[k*DATA_W +: DATA_W] = w_data;
    assign o_rd_pend[k]                  = w_pend;
  end

endmodule

// File: tb/tb_fp_regfile_mp.sv
// Randomized plus directed bench for fp_regfile_mp against an array-level
// reference model; follows FP_RF_BYPASS_EN when the macro is defined.
module tb_fp_regfile_mp;

  localparam int DW = 32;
  localparam int DP = 32;
  localparam int NR = 3;
  localparam int AW = 5;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [NR*AW-1:0] rd_addr;
  logic [NR*DW-1:0] rd_data;
  logic [NR-1:0]    rd_pend;
  logic             wr0_en, wr1_en, sb_set_en, clr_req;
  logic [AW-1:0]    wr0_addr, wr1_addr, sb_set_addr;
  logic [DW-1:0]    wr0_data, wr1_data;
  logic             clr_busy, clr_done;

  fp_regfile_mp #(.DATA_W(DW), .DEPTH(DP), .NUM_RD(NR)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_rd_addr     (rd_addr),
    .o_rd_data     (rd_data),
    .o_rd_pend     (rd_pend),
    .i_wr0_en      (wr0_en),
    .i_wr0_addr    (wr0_addr),
    .i_wr0_data    (wr0_data),
    .i_wr1_en      (wr1_en),
    .i_wr1_addr    (wr1_addr),
    .i_wr1_data    (wr1_data),
    .i_sb_set_en   (sb_set_en),
    .i_sb_set_addr (sb_set_addr),
    .i_clr_req     (clr_req),
    .o_clr_busy    (clr_busy),
    .o_clr_done    (clr_done)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: plain array, pending vector, and a count of
  // registers the sweep still has to zero.
  logic [DW-1:0] m_mem [DP];
  logic [DP-1:0] m_pend;
  int            m_left;
  bit            m_done;

  task automatic cmp(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < DP; i++) m_mem[i] = '0;
    m_pend = '0;
    m_left = 0;
    m_done = 1'b0;
  endtask

  task automatic model_update();
    bit prev_done;
    if (m_left > 0) begin
      m_mem[DP - m_left]  = '0;
      m_pend[DP - m_left] = 1'b0;
      m_left--;
      m_done = (m_left == 0);
    end else begin
      if (wr1_en)    m_mem[wr1_addr] = wr1_data;
      if (wr0_en)    m_mem[wr0_addr] = wr0_data;
      if (wr1_en)    m_pend[wr1_addr] = 1'b0;
      if (sb_set_en) m_pend[sb_set_addr] = 1'b1;
      prev_done = m_done;
      m_done = 1'b0;
      if (clr_req && !prev_done) m_left = DP;
    end
  endtask

  task automatic check_all();
    logic [AW-1:0] a;
    logic [DW-1:0] ed;
    logic          ep;
    for (int k = 0; k < NR; k++) begin
      a  = rd_addr[k*AW +: AW];
      ed = m_mem[a];
      ep = m_pend[a];
`ifdef FP_RF_BYPASS_EN
      if (m_left == 0) begin
        if (wr0_en && wr0_addr == a)      ed = wr0_data;
        else if (wr1_en && wr1_addr == a) ed = wr1_data;
        if (sb_set_en && sb_set_addr == a) ep = 1'b1;
        else if (wr1_en && wr1_addr == a)  ep = 1'b0;
      end
`endif
      cmp($sformatf("rd_data[%0d]", k), rd_data[k*DW +: DW], ed);
      cmp($sformatf("rd_pend[%0d]", k), {31'b0, rd_pend[k]}, {31'b0, ep});
    end
    cmp("clr_busy", {31'b0, clr_busy}, {31'b0, m_left > 0});
    cmp("clr_done", {31'b0, clr_done}, {31'b0, m_done});
  endtask

  // Called at a negedge with inputs already driven.
  task automatic tick();
    #1 check_all();
    @(posedge clk);
    if (rst_n) model_update();
    @(negedge clk);
  endtask

  task automatic idle();
    wr0_en = 0; wr1_en = 0; sb_set_en = 0; clr_req = 0;
  endtask

  int busy_cnt, done_cnt, done_at;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 0; rd_addr = '0;
    wr0_addr = '0; wr1_addr = '0; sb_set_addr = '0; wr0_data = '0; wr1_data = '0;
    idle();
    model_reset();
    @(negedge clk); @(negedge clk);
    rst_n = 1;

    // Reset contents on every index and port.
    for (int i = 0; i < DP; i++) begin
      rd_addr = {AW'(i), AW'(i), AW'(i)};
      #1 cmp("reset_data", rd_data[2*DW +: DW], 32'h0);
      cmp("reset_pend", {29'b0, rd_pend}, 32'h0);
      tick();
    end

    // Same-index dual write: wr0 wins.
    wr0_en = 1; wr0_addr = 5; wr0_data = 32'h3F800000;
    wr1_en = 1; wr1_addr = 5; wr1_data = 32'h40000000;
    tick();
    idle(); rd_addr = {AW'(0), AW'(0), AW'(5)};
    #1 cmp("wr_prio", rd_data[0 +: DW], 32'h3F800000);
    tick();

    // Scoreboard set, hold, clear by wr1; then set beats clear.
    sb_set_en = 1; sb_set_addr = 7; rd_addr = {AW'(0), AW'(7), AW'(0)};
    tick();
    idle();
    for (int c = 0; c < 3; c++) begin
      #1 cmp("pend_hold", {31'b0, rd_pend[1]}, 32'h1);
      tick();
    end
    wr1_en = 1; wr1_addr = 7; wr1_data = 32'h40490FDB;
    tick();
    idle();
    #1 cmp("pend_clr", {31'b0, rd_pend[1]}, 32'h0);
    cmp("wr1_data", rd_data[DW +: DW], 32'h40490FDB);
    sb_set_en = 1; sb_set_addr = 7; wr1_en = 1; wr1_addr = 7; wr1_data = 32'h1234;
    tick();
    idle();
    #1 cmp("set_over_clr", {31'b0, rd_pend[1]}, 32'h1);
    tick();

    // Fill, sweep, and attempt writes/requests during the sweep.
    for (int i = 0; i < DP; i++) begin
      wr0_en = 1; wr0_addr = AW'(i); wr0_data = 32'h1000 + i;
      sb_set_en = 1; sb_set_addr = AW'(i);
      tick();
    end
    idle();
    clr_req = 1;
    tick();
    busy_cnt = 0; done_cnt = 0; done_at = -1;
    for (int c = 0; c < 40; c++) begin
      clr_req = (c == 10 || c == 32);
      wr0_en = (c == 4); wr0_addr = 3; wr0_data = 32'h1;
      sb_set_en = (c == 6); sb_set_addr = 31;
      rd_addr = {AW'(c), AW'(3), AW'(31)};
      #1;
      if (clr_busy) busy_cnt++;
      if (clr_done) begin done_cnt++; done_at = c; end
      tick();
    end
    idle();
    cmp("busy_cycles", busy_cnt, 32);
    cmp("done_pulses", done_cnt, 1);
    cmp("done_cycle", done_at, 32);
    rd_addr = {AW'(31), AW'(3), AW'(0)};
    #1 cmp("reg3_cleared", rd_data[DW +: DW], 32'h0);
    for (int i = 0; i < DP; i++) begin
      rd_addr = {AW'(i), AW'(DP - 1 - i), AW'(i)};
      tick();
    end

    // Reset in the middle of a sweep.
    for (int i = 20; i < 26; i++) begin
      wr0_en = 1; wr0_addr = AW'(i); wr0_data = 32'hABC00 + i;
      tick();
    end
    idle();
    clr_req = 1;
    tick();
    clr_req = 0;
    rd_addr = {AW'(22), AW'(25), AW'(20)};
    for (int c = 0; c < 9; c++) tick();
    #2 rst_n = 0;
    model_reset();
    #1 cmp("rst_busy", {31'b0, clr_busy}, 32'h0);
    cmp("rst_data", rd_data[0 +: DW], 32'h0);
    tick();
    rst_n = 1;
    clr_req = 1;
    tick();
    clr_req = 0;
    #1 cmp("reaccept_busy", {31'b0, clr_busy}, 32'h1);
    for (int c = 0; c < 34; c++) tick();

    // Same-cycle bypass on port 2.
    wr0_en = 1; wr0_addr = 9; wr0_data = 32'h12345678;
    tick();
    wr0_data = 32'hC0000000; rd_addr = {AW'(9), AW'(0), AW'(0)};
`ifdef FP_RF_BYPASS_EN
    #1 cmp("bypass", rd_data[2*DW +: DW], 32'hC0000000);
`else
    #1 cmp("no_bypass", rd_data[2*DW +: DW], 32'h12345678);
`endif
    tick();
    idle();
    #1 cmp("post_write", rd_data[2*DW +: DW], 32'hC0000000);

    // Randomized traffic.
    for (int c = 0; c < 1500; c++) begin
      wr0_en = 1'($urandom_range(0, 1)); wr0_addr = AW'($urandom); wr0_data = $urandom;
      wr1_en = 1'($urandom_range(0, 1)); wr1_addr = AW'($urandom); wr1_data = $urandom;
      if ($urandom_range(0, 3) == 0) wr1_addr = wr0_addr;
      sb_set_en = 1'($urandom_range(0, 1)); sb_set_addr = AW'($urandom);
      if ($urandom_range(0, 3) == 0) sb_set_addr = wr1_addr;
      clr_req = ($urandom_range(0, 63) == 0);
      rd_addr = NR*AW'($urandom);
      if ($urandom_range(0, 2) == 0) rd_addr[AW-1:0] = wr0_addr;
      if ($urandom_range(0, 2) == 0) rd_addr[AW +: AW] = wr1_addr;
      tick();
    end
    idle();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fp_regfile_mp.md
Name: fp_regfile_mp

Overview:
Parametrised multi-port floating-point register file, the next generation of the FP register storage in the MIPS datapath.
- Adds configurable width, depth and read-port count.
- Adds a second write port for long-latency FP units.
- Adds a per-register pending scoreboard for hazard detection.
- Adds a sequenced clear engine that zeroes the file without a reset.
Sits between FP decode/issue (reads, scoreboard set) and FP writeback.

Parameters:
DATA_W, 32, register width in bits
DEPTH, 32, number of registers (power of two, >= 2)
NUM_RD, 3, number of read ports (3 covers fused multiply-add)
ADDR_W (localparam), clog2(DEPTH), register index width

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
rd_addr  in  NUM_RD*ADDR_W  read indices, port k at bits [k*ADDR_W +: ADDR_W]
rd_data  out  NUM_RD*DATA_W  read data, port k at bits [k*DATA_W +: DATA_W]
rd_pend  out  NUM_RD  pending bit of addressed register, per port
wr0_en  in  1  pipeline writeback enable
wr0_addr  in  ADDR_W  pipeline writeback index
wr0_data  in  DATA_W  pipeline writeback data
wr1_en  in  1  long-latency unit writeback enable (div/sqrt)
wr1_addr  in  ADDR_W  long-latency writeback index
wr1_data  in  DATA_W  long-latency writeback data
sb_set_en  in  1  mark destination pending (long op issued)
sb_set_addr  in  ADDR_W  index to mark pending
clr_req  in  1  request full clear sweep
clr_busy  out  1  sweep in progress
clr_done  out  1  one-cycle pulse when sweep finishes

Behaviour:
- Reset (rst_n low, async): all registers 0, all pending bits 0, FSM IDLE, sweep pointer 0, clr_busy 0, clr_done 0.
- Clock and reset: single clock domain; reset is asynchronous, active-low (rst_n).
- Reads:
  - Combinational from array and pending state, zero latency.
  - A write at edge N is visible on reads after edge N.
- Writes:
  - Both ports commit at the rising edge.
  - wr0 and wr1 enabled to the same index: wr0 wins (younger instruction).
  - Different indices: both commit.
- Scoreboard:
  - sb_set_en sets pend[sb_set_addr].
  - wr1_en clears pend[wr1_addr].
  - Set and clear to the same index in one cycle: set wins.
  - wr0 does not touch pending bits.
- Clear FSM:
  - States IDLE, SWEEP, DONE.
  - IDLE: clr_req moves to SWEEP, pointer 0, clr_busy 1.
  - SWEEP: each cycle zeroes reg[ptr] and pend[ptr], then ptr++. When ptr == DEPTH-1 is cleared, go to DONE.
  - DONE: clr_done 1 for exactly one cycle, clr_busy 0, then IDLE.
  - Sweep takes DEPTH cycles; clr_done is asserted in cycle DEPTH+1 after acceptance.
  - clr_req while SWEEP or DONE: ignored, not queued.
  - While clr_busy is 1: wr0, wr1 and sb_set are ignored (dropped). Reads remain live and may return partially cleared contents.
  - rst_n low mid-sweep: immediate abort to reset state.
- Address width: indices are exactly ADDR_W bits, with no out-of-range handling required.

Optional Feature:
Macro FP_RF_BYPASS_EN.
- Defined, data: a read index matching an enabled same-cycle write returns the write data (wr0 over wr1).
- Defined, pending: rd_pend for an index being cleared by a same-cycle wr1 reads 0. For an index being set by sb_set it reads 1.
- Defined, during clear: no bypass while clr_busy.
- Undefined: reads return pre-edge array and pending state only.

Decomposition:
- Shared package fp_rf_pkg: clear FSM state enum (IDLE/SWEEP/DONE); default DATA_W/DEPTH/NUM_RD constants.
- One natural sub-module, fp_rf_clr_seq: the clear FSM and pointer. It outputs a clear strobe, clear index, clr_busy and clr_done.
- The top level holds the array, pending vector, write priority, bypass and read muxes.

Test Plan:
- Reset then read all 32 indices on 3 ports -> rd_data 0, rd_pend 0.
- wr0 reg5=0x3F800000 and wr1 reg5=0x40000000 same cycle -> next cycle reg5 reads 0x3F800000.
- sb_set reg7, 4 cycles later wr1 reg7=0x40490FDB -> rd_pend for 7 is 1 in between, then 0 with data 0x40490FDB. Also check same-cycle sb_set + wr1 on reg7 -> pend stays 1.
- Fill all regs, pulse clr_req, issue wr0 reg3=0x1 during sweep -> clr_busy high 32 cycles, clr_done single pulse, all regs 0, reg3 still 0.
- Start sweep, drop rst_n at cycle 10 -> clr_busy 0 immediately, all regs 0, FSM accepts a new clr_req after release.
- With FP_RF_BYPASS_EN, wr0 reg9=0xC0000000 while rd_addr port2=9 -> same-cycle rd_data 0xC0000000. Without the macro -> old value.
